// File: rtl/alu_seq_core_if.sv
// Operand/command/result bundle for alu_seq_core.
// master: the side that supplies operands and consumes results.
// slave:  the alu_seq_core datapath itself.
interface alu_seq_core_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 4
);
    logic            CE;
    logic            MODE;
    logic [CW-1:0]   CMD;
    logic [1:0]      INP_VALID;
    logic [DW-1:0]   OPA;
    logic [DW-1:0]   OPB;
    logic            CIN;
    logic            BUSY;
    logic            RES_VALID;
    logic [2*DW-1:0] RES;
    logic            COUT;
    logic            OFLOW;
    logic            G;
    logic            E;
    logic            L;
    logic            ERR;

    modport master (
        output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        input  BUSY, RES_VALID, RES, COUT, OFLOW, G, E, L, ERR
    );

    modport slave (
        input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        output BUSY, RES_VALID, RES, COUT, OFLOW, G, E, L, ERR
    );
endinterface

// File: rtl/alu_seq_core.sv
// Sequential ALU: collects two operands (possibly on different cycles),
// executes an arithmetic or logic command and registers the result with a
// one-cycle RES_VALID pulse. A missing operand times out after TIMEOUT waits.
// Optional multiplier (arith commands 9/10, extra MUL cycle) when the macro
// ALU_SEQ_MUL_EN is defined; otherwise those codes are treated as undefined.
module alu_seq_core #(
    parameter int unsigned DW      = 8,
    parameter int unsigned CW      = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input logic           CLK,
    input logic           RST_N,
    alu_seq_core_if.slave bus
);
    localparam int unsigned     LG      = $clog2(DW);
    localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [DW-1:0]   ONE     = DW'(1);
    localparam logic [DW:0]     ONE_X   = (DW+1)'(1);

    typedef enum logic [2:0] {IDLE, WAIT_A, WAIT_B, EXEC, MUL, DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [DW-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [CW-1:0]   cmd_q, cmd_d;
    logic            mode_q, mode_d, cin_q, cin_d;
    logic [2*DW-1:0] res_q, res_d;
    logic [5:0]      flg_q, flg_d;     // {COUT, OFLOW, G, E, L, ERR}
    logic            vld_q, vld_d;

    logic [2*DW-1:0] alu_res;
    logic [5:0]      alu_flg;
    logic            is_mul;
    logic            complete;

`ifdef ALU_SEQ_MUL_EN
    logic [DW-1:0]   mul_a, mul_b;
    logic [2*DW-1:0] prod;

    // Multiplier operands are truncated to DW bits before the product.
    always_comb begin
        if (cmd_q == CW'(9)) begin
            mul_a = opa_q + ONE;
            mul_b = opb_q + ONE;
        end else begin
            mul_a = opa_q << 1;
            mul_b = opb_q;
        end
        prod = {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
    end

    assign is_mul = mode_q && ((cmd_q == CW'(9)) || (cmd_q == CW'(10)));
`else
    assign is_mul = 1'b0;
`endif

    // Single-cycle datapath on the captured operands.
    always_comb begin
        logic [DW:0]    a_x, b_x, c_x, ext;
        logic [DW-1:0]  lres;
        logic [LG-1:0]  sh;
        logic           cout, ofl, g, e, l, err;
        a_x  = {1'b0, opa_q};
        b_x  = {1'b0, opb_q};
        c_x  = {{DW{1'b0}}, cin_q};
        sh   = opb_q[LG-1:0];
        ext  = '0;
        lres = '0;
        cout = 1'b0;
        ofl  = 1'b0;
        g    = 1'b0;
        e    = 1'b0;
        l    = 1'b0;
        err  = 1'b0;
        if (mode_q) begin
            case (cmd_q)
                CW'(0):  begin ext = a_x + b_x;         cout = ext[DW]; end
                CW'(1):  begin ext = a_x - b_x;         ofl  = ext[DW]; end
                CW'(2):  begin ext = a_x + b_x + c_x;   cout = ext[DW]; end
                CW'(3):  begin ext = a_x - b_x - c_x;   ofl  = ext[DW]; end
                CW'(4):  begin ext = a_x + ONE_X;       cout = ext[DW]; end
                CW'(5):  begin ext = a_x - ONE_X;       ofl  = ext[DW]; end
                CW'(6):  begin ext = b_x + ONE_X;       cout = ext[DW]; end
                CW'(7):  begin ext = b_x - ONE_X;       ofl  = ext[DW]; end
                CW'(8):  begin
                    g = opa_q > opb_q;
                    e = opa_q == opb_q;
                    l = opa_q < opb_q;
                end
                default: err = 1'b1;
            endcase
            lres = ext[DW-1:0];
        end else begin
            case (cmd_q)
                CW'(0):  lres = opa_q & opb_q;
                CW'(1):  lres = ~(opa_q & opb_q);
                CW'(2):  lres = opa_q | opb_q;
                CW'(3):  lres = ~(opa_q | opb_q);
                CW'(4):  lres = opa_q ^ opb_q;
                CW'(5):  lres = ~(opa_q ^ opb_q);
                CW'(6):  lres = ~opa_q;
                CW'(7):  lres = ~opb_q;
                CW'(8):  lres = opa_q >> 1;
                CW'(9):  lres = opa_q << 1;
                CW'(10): lres = opb_q >> 1;
                CW'(11): lres = opb_q << 1;
                CW'(12): begin
                    lres = (opa_q << sh) | (opa_q >> (DW - int'(sh)));
                    err  = |opb_q[DW-1:LG+1];
                end
                CW'(13): begin
                    lres = (opa_q >> sh) | (opa_q << (DW - int'(sh)));
                    err  = |opb_q[DW-1:LG+1];
                end
                default: err = 1'b1;
            endcase
        end
        alu_res = {{DW{1'b0}}, lres};
        alu_flg = {cout, ofl, g, e, l, err};
    end

    // Operand collection, wait timeout and result sequencing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        cmd_d    = cmd_q;
        mode_d   = mode_q;
        cin_d    = cin_q;
        res_d    = res_q;
        flg_d    = flg_q;
        vld_d    = vld_q;
        complete = 1'b0;
        if (bus.CE) begin
            vld_d = 1'b0;
            case (state_q)
                IDLE, WAIT_A, WAIT_B: begin
                    // Completion is whichever operand is still missing; both
                    // valid always completes.
                    case (state_q)
                        WAIT_B:  complete = bus.INP_VALID[1];
                        WAIT_A:  complete = bus.INP_VALID[0];
                        default: complete = &bus.INP_VALID;
                    endcase
                    if (bus.INP_VALID[0]) opa_d = bus.OPA;
                    if (bus.INP_VALID[1]) opb_d = bus.OPB;
                    if (|bus.INP_VALID) begin
                        cmd_d  = bus.CMD;
                        mode_d = bus.MODE;
                        cnt_d  = '0;
                    end
                    if (complete) begin
                        cin_d   = bus.CIN;
                        state_d = EXEC;
                    end else if (bus.INP_VALID == 2'b01) begin
                        state_d = WAIT_B;
                    end else if (bus.INP_VALID == 2'b10) begin
                        state_d = WAIT_A;
                    end else if (state_q != IDLE) begin
                        if (cnt_q == TO_LAST) begin
                            res_d   = '0;
                            flg_d   = 6'b000001;
                            vld_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                EXEC: begin
                    if (is_mul) begin
                        state_d = MUL;
                    end else begin
                        res_d   = alu_res;
                        flg_d   = alu_flg;
                        vld_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    res_d   = prod;
                    flg_d   = '0;
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers; CE gating lives in the next-state logic.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cmd_q   <= cmd_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.BUSY      = (state_q == EXEC) || (state_q == MUL);
    assign bus.RES_VALID = vld_q;
    assign bus.RES       = res_q;
    assign {bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR} = flg_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core (DW=8, CW=4, TIMEOUT=16).
// Multiply expectations follow ALU_SEQ_MUL_EN as seen by the bench build.
module tb_alu_seq_core;
    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    alu_seq_core_if #(.DW(8), .CW(4)) bus ();

    alu_seq_core #(.DW(8), .CW(4), .TIMEOUT(16)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        bus.MODE      = m;
        bus.CMD       = c;
        bus.INP_VALID = iv;
        bus.OPA       = a;
        bus.OPB       = b;
        bus.CIN       = ci;
    endtask

    // Called right after the completing edge: BUSY for lat cycles, then the pulse.
    task automatic finish_op(input string tag, input int lat,
                             input logic [15:0] er, input logic [5:0] ef);
        for (int i = 0; i < lat; i++) begin
            check({tag, ":busy"},  32'(bus.BUSY), 32'd1);
            check({tag, ":early"}, 32'(bus.RES_VALID), 32'd0);
            tick();
        end
        check({tag, ":vld"},      32'(bus.RES_VALID), 32'd1);
        check({tag, ":busy_end"}, 32'(bus.BUSY), 32'd0);
        check({tag, ":res"},      32'(bus.RES), 32'(er));
        check({tag, ":flg"},      flags(), 32'(ef));
    endtask

    task automatic apply(input string tag, input logic m, input logic [3:0] c,
                         input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [15:0] er, input logic [5:0] ef, input int lat);
        drive(m, c, 2'b11, a, b, ci);
        tick();
        bus.INP_VALID = 2'b00;
        finish_op(tag, lat, er, ef);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // flags vector order: {COUT, OFLOW, G, E, L, ERR}
    initial begin
        rst_n  = 1'b0;
        bus.CE = 1'b1;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        ticks(2);
        check("rst_res",  32'(bus.RES), 32'd0);
        check("rst_vld",  32'(bus.RES_VALID), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_flg",  flags(), 32'd0);
        rst_n = 1'b1;
        tick();

        // Arithmetic
        apply("add_ff_01", 1'b1, 4'd0,  8'hFF, 8'h01, 1'b0, 16'h0000, 6'b100000, 1);
        apply("sub_neg",   1'b1, 4'd1,  8'h03, 8'h05, 1'b0, 16'h00FE, 6'b010000, 1);
        apply("addc",      1'b1, 4'd2,  8'h10, 8'h20, 1'b1, 16'h0031, 6'b000000, 1);
        apply("subb",      1'b1, 4'd3,  8'h05, 8'h05, 1'b1, 16'h00FF, 6'b010000, 1);
        apply("inca",      1'b1, 4'd4,  8'hFF, 8'h00, 1'b0, 16'h0000, 6'b100000, 1);
        apply("deca",      1'b1, 4'd5,  8'h00, 8'h00, 1'b0, 16'h00FF, 6'b010000, 1);
        apply("incb",      1'b1, 4'd6,  8'h12, 8'h7F, 1'b0, 16'h0080, 6'b000000, 1);
        apply("decb",      1'b1, 4'd7,  8'h12, 8'h01, 1'b0, 16'h0000, 6'b000000, 1);
        apply("cmp_gt",    1'b1, 4'd8,  8'h05, 8'h03, 1'b0, 16'h0000, 6'b001000, 1);
        apply("cmp_eq",    1'b1, 4'd8,  8'h07, 8'h07, 1'b0, 16'h0000, 6'b000100, 1);
        apply("cmp_lt",    1'b1, 4'd8,  8'h02, 8'h09, 1'b0, 16'h0000, 6'b000010, 1);
        apply("arith_und", 1'b1, 4'd11, 8'h12, 8'h34, 1'b0, 16'h0000, 6'b000001, 1);
`ifdef ALU_SEQ_MUL_EN
        apply("mul9",      1'b1, 4'd9,  8'h0F, 8'h0F, 1'b0, 16'h0100, 6'b000000, 2);
        apply("mul10",     1'b1, 4'd10, 8'h7F, 8'hFF, 1'b0, 16'hFD02, 6'b000000, 2);
        apply("mul9_wrap", 1'b1, 4'd9,  8'hFF, 8'h02, 1'b0, 16'h0000, 6'b000000, 2);
`else
        apply("mul9_off",  1'b1, 4'd9,  8'h0F, 8'h0F, 1'b0, 16'h0000, 6'b000001, 1);
        apply("mul10_off", 1'b1, 4'd10, 8'h7F, 8'hFF, 1'b0, 16'h0000, 6'b000001, 1);
`endif

        // Logic
        apply("and",       1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 16'h0030, 6'b000000, 1);
        apply("nand",      1'b0, 4'd1,  8'hF0, 8'h3C, 1'b0, 16'h00CF, 6'b000000, 1);
        apply("or",        1'b0, 4'd2,  8'hF0, 8'h3C, 1'b0, 16'h00FC, 6'b000000, 1);
        apply("nor",       1'b0, 4'd3,  8'hF0, 8'h3C, 1'b0, 16'h0003, 6'b000000, 1);
        apply("xor",       1'b0, 4'd4,  8'hF0, 8'h3C, 1'b0, 16'h00CC, 6'b000000, 1);
        apply("xnor",      1'b0, 4'd5,  8'hF0, 8'h3C, 1'b0, 16'h0033, 6'b000000, 1);
        apply("nota",      1'b0, 4'd6,  8'hF0, 8'h3C, 1'b0, 16'h000F, 6'b000000, 1);
        apply("notb",      1'b0, 4'd7,  8'hF0, 8'h3C, 1'b0, 16'h00C3, 6'b000000, 1);
        apply("shra",      1'b0, 4'd8,  8'h81, 8'h3C, 1'b0, 16'h0040, 6'b000000, 1);
        apply("shla",      1'b0, 4'd9,  8'h81, 8'h3C, 1'b0, 16'h0002, 6'b000000, 1);
        apply("shrb",      1'b0, 4'd10, 8'h81, 8'h3C, 1'b0, 16'h001E, 6'b000000, 1);
        apply("shlb",      1'b0, 4'd11, 8'h81, 8'h3C, 1'b0, 16'h0078, 6'b000000, 1);
        apply("rol1",      1'b0, 4'd12, 8'h81, 8'h01, 1'b0, 16'h0003, 6'b000000, 1);
        apply("rol_err",   1'b0, 4'd12, 8'h81, 8'h11, 1'b0, 16'h0003, 6'b000001, 1);
        apply("ror1",      1'b0, 4'd13, 8'h81, 8'h01, 1'b0, 16'h00C0, 6'b000000, 1);
        apply("ror_b3",    1'b0, 4'd13, 8'h81, 8'h08, 1'b0, 16'h0081, 6'b000000, 1);
        apply("logic_und", 1'b0, 4'd14, 8'h81, 8'h01, 1'b0, 16'h0000, 6'b000001, 1);

        // A first, B three idle cycles later, multiply command
        drive(1'b1, 4'd9, 2'b01, 8'd5, 8'h00, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
        ticks(3);
        drive(1'b1, 4'd9, 2'b10, 8'h00, 8'd3, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
`ifdef ALU_SEQ_MUL_EN
        finish_op("wait_mul", 2, 16'd24, 6'b000000);
`else
        finish_op("wait_mul", 1, 16'd0, 6'b000001);
`endif

        // B first, then A (WAIT_A path)
        drive(1'b0, 4'd2, 2'b10, 8'h00, 8'h22, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
        ticks(2);
        drive(1'b0, 4'd2, 2'b01, 8'h11, 8'h00, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
        finish_op("waita_or", 1, 16'h0033, 6'b000000);

        // Timeout on the 16th wait edge
        drive(1'b1, 4'd0, 2'b01, 8'h05, 8'h00, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
        ticks(15);
        check("to_early", 32'(bus.RES_VALID), 32'd0);
        check("to_busy",  32'(bus.BUSY), 32'd0);
        tick();
        check("to_vld", 32'(bus.RES_VALID), 32'd1);
        check("to_res", 32'(bus.RES), 32'd0);
        check("to_flg", flags(), 32'b000001);
        bus.CE = 1'b0;
        tick();
        check("ce_hold_vld", 32'(bus.RES_VALID), 32'd1);
        bus.CE = 1'b1;
        tick();
        check("vld_pulse", 32'(bus.RES_VALID), 32'd0);

        // Re-accepting A restarts the wait count
        drive(1'b1, 4'd0, 2'b01, 8'h40, 8'h00, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
        ticks(10);
        drive(1'b1, 4'd0, 2'b01, 8'h20, 8'h00, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
        ticks(15);
        check("restart_early", 32'(bus.RES_VALID), 32'd0);
        tick();
        check("restart_to", 32'(bus.RES_VALID), 32'd1);
        check("restart_flg", flags(), 32'b000001);

        // CE low for 5 cycles in WAIT_B freezes the counter
        drive(1'b1, 4'd0, 2'b01, 8'h05, 8'h00, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
        ticks(5);
        bus.CE = 1'b0;
        ticks(5);
        check("ce_off_vld", 32'(bus.RES_VALID), 32'd0);
        bus.CE = 1'b1;
        ticks(10);
        check("ce_frozen_early", 32'(bus.RES_VALID), 32'd0);
        tick();
        check("ce_frozen_to", 32'(bus.RES_VALID), 32'd1);
        check("ce_frozen_flg", flags(), 32'b000001);

        // Completion on the timeout edge wins
        drive(1'b1, 4'd0, 2'b01, 8'h10, 8'h00, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
        ticks(15);
        check("race_early", 32'(bus.RES_VALID), 32'd0);
        drive(1'b1, 4'd0, 2'b10, 8'h00, 8'h01, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
        finish_op("to_race", 1, 16'h0011, 6'b000000);

        // Reset while busy
        drive(1'b1, 4'd9, 2'b11, 8'd5, 8'd3, 1'b0);
        tick();
        bus.INP_VALID = 2'b00;
`ifdef ALU_SEQ_MUL_EN
        tick();
`endif
        check("pre_rst_busy", 32'(bus.BUSY), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        check("mid_rst_res",  32'(bus.RES), 32'd0);
        check("mid_rst_vld",  32'(bus.RES_VALID), 32'd0);
        check("mid_rst_flg",  flags(), 32'd0);
        ticks(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_vld",  32'(bus.RES_VALID), 32'd0);
            check("post_rst_busy", 32'(bus.BUSY), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter DW, 8, operand width in bits (DW >= 4, power of two).
REQ-002 Parameter CW, 4, command width in bits.
REQ-003 Parameter TIMEOUT, 16, number of wait cycles allowed for a missing operand (1..255).
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 CE  in  1  clock enable; when 0, all state, counters and outputs hold.
REQ-007 MODE  in  1  1 = arithmetic command set, 0 = logic command set.
REQ-008 CMD  in  CW  command code, captured with every accepted operand.
REQ-009 INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid.
REQ-010 OPA, OPB  in  DW each  operands.
REQ-011 CIN  in  1  carry/borrow in, captured with the completing operand.
REQ-012 BUSY  out  1  1 while executing; inputs are ignored while BUSY = 1.
REQ-013 RES_VALID  out  1  one-cycle pulse marking a new RES/flag set.
REQ-014 RES  out  2*DW  result, zero-extended.
REQ-015 COUT, OFLOW, G, E, L, ERR  out  1 each  carry, borrow, greater, equal, less, error.

Function
REQ-016 FSM states: IDLE, WAIT_A (holding OPB), WAIT_B (holding OPA), EXEC, MUL, DONE; all transitions require CE = 1.
REQ-017 IDLE/WAIT_*: INP_VALID = 11 captures both operands, CMD, MODE and CIN -> EXEC; 01 -> WAIT_B; 10 -> WAIT_A; 00 -> no change.
REQ-018 In WAIT_B, 01 replaces OPA/CMD/MODE and restarts the wait counter; 10 or 11 supplies the missing operand -> EXEC; WAIT_A is symmetric.
REQ-019 The wait counter clears on each partial accept and increments on each enabled WAIT cycle without completion; on the edge where it would reach TIMEOUT: ERR = 1, RES = 0, RES_VALID = 1, -> IDLE.
REQ-020 A completing operand on the same edge as timeout wins; no ERR.
REQ-021 EXEC: single-cycle commands register the result on the next edge with RES_VALID = 1 (latency 1 after completion); multiply commands go EXEC -> MUL and register the result one edge later (latency 2).
REQ-022 Every new result clears all unused flags; RES and flags hold between RES_VALID pulses.
REQ-023 Arithmetic (MODE = 1): 0 A+B, 1 A-B, 2 A+B+CIN, 3 A-B-CIN, 4 A+1, 5 A-1, 6 B+1, 7 B-1, 8 compare, 9 (A+1)*(B+1), 10 (A<<1)*B; all unsigned.
REQ-024 COUT = bit DW of the sum for commands 0/2/4/6; OFLOW = 1 when the true result is negative for 1/3/5/7; RES holds the low DW bits for all non-multiply arithmetic.
REQ-025 Compare: exactly one of G/E/L = 1, RES = 0.
REQ-026 Multiply: full 2*DW-bit product with operands truncated to DW bits before the multiply; (A<<1) discards the MSB.
REQ-027 Logic (MODE = 0): 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 ~A, 7 ~B, 8 A>>1, 9 A<<1, 10 B>>1, 11 B<<1, 12 rotate A left by B[log2(DW)-1:0], 13 rotate A right by same.
REQ-028 Rotate with any OPB bit at or above log2(DW)+1 set: ERR = 1 with the rotated RES still produced.
REQ-029 Undefined command codes produce RES = 0 and ERR = 1 with the normal single-cycle latency.
REQ-030 BUSY = 1 in EXEC and MUL only; state -> IDLE after the result edge.

Reset
REQ-031 RST_N = 0 immediately forces IDLE, clears the counter and captured operands, and sets RES = 0, RES_VALID = 0, BUSY = 0 and all flags = 0, independent of CE.
REQ-032 Reset during EXEC/MUL discards the operation; no RES_VALID follows release.

Configuration
REQ-033 Macro ALU_SEQ_MUL_EN defined: commands 9/10 and the MUL state are implemented as specified.
REQ-034 ALU_SEQ_MUL_EN undefined: no multiplier; arithmetic 9/10 behave as undefined codes (RES = 0, ERR = 1, latency 1).

Verification
REQ-035 DW = 8, INP_VALID = 11, MODE = 1, CMD = 0, A = 0xFF, B = 0x01 -> one edge later RES_VALID = 1, RES = 0x000, COUT = 1.
REQ-036 Accept A = 5 (01); after 3 idle cycles accept B = 3 (10), CMD = 9 -> RES = 24 two edges after completion, BUSY high for 2 cycles.
REQ-037 Accept A only, TIMEOUT = 16, then INP_VALID = 00 -> on the 16th wait edge ERR = 1, RES_VALID = 1, state IDLE.
REQ-038 MODE = 0, CMD = 12, A = 0x81, B = 0x01 -> RES = 0x03; with B = 0x11 -> RES = 0x03, ERR = 1.
REQ-039 Assert RST_N low mid-MUL -> all outputs 0 at once, no RES_VALID after release; CE = 0 for 5 cycles during WAIT_B -> counter frozen.
